// File: rtl/irq_exc_pkg.sv
// irq_exc_pkg: shared state encoding, cause/vector constants and width helpers for irq_exc_ctrl
package irq_exc_pkg;
   typedef enum logic [1:0] {
      ST_USER    = 2'd0,
      ST_HANDLER = 2'd1,
      ST_RESUME  = 2'd2
   } irq_state_e;
   localparam logic CAUSE_ILLOP = 1'b1;
   localparam logic [31:0] VEC_IRQ_DFLT = 32'h8000_0004;
   localparam logic [31:0] VEC_EXC_DFLT = 32'h8000_0008;
   function automatic int cause_w(input int n);
      return $clog2(n) + 1;
   endfunction
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/irq_arbiter.sv
// irq_arbiter: combinational pick of one pending IRQ; round-robin when IRQ_CTRL_RR_EN is defined,
// otherwise fixed priority with the lowest index winning.
module irq_arbiter
   import irq_exc_pkg::*;
#(
   parameter int N_IRQ = 4
) (
`ifdef IRQ_CTRL_RR_EN
   input  logic [id_w(N_IRQ)-1:0] ptr_i,
`endif
   input  logic [N_IRQ-1:0]       pend_i,
   output logic                   valid_o,
   output logic [id_w(N_IRQ)-1:0] id_o
);
   localparam int IW = id_w(N_IRQ);
   assign valid_o = |pend_i;
   // Loops run from lowest to highest priority so the last hit wins.
   always_comb begin
      id_o = '0;
`ifdef IRQ_CTRL_RR_EN
      for (int k = N_IRQ; k >= 1; k--)
         if (pend_i[(int'(ptr_i) + k) % N_IRQ]) id_o = IW'((int'(ptr_i) + k) % N_IRQ);
`else
      for (int i = N_IRQ - 1; i >= 0; i--)
         if (pend_i[i]) id_o = IW'(i);
`endif
   end
endmodule

// File: rtl/irq_exc_ctrl.sv
// irq_exc_ctrl: EX-stage interrupt/illegal-opcode controller issuing a one-cycle flush/redirect,
// capturing EPC/cause and tracking USER/HANDLER/RESUME. IRQ_CTRL_RR_EN selects round-robin arbitration.
module irq_exc_ctrl
   import irq_exc_pkg::*;
#(
   parameter int               N_IRQ    = 4,
   parameter int               PC_W     = 32,
   parameter logic [PC_W-1:0]  VEC_IRQ  = PC_W'(VEC_IRQ_DFLT),
   parameter logic [PC_W-1:0]  VEC_EXC  = PC_W'(VEC_EXC_DFLT),
   parameter logic [N_IRQ-1:0] MASK_RST = '1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [N_IRQ-1:0]          irq_i,
   input  logic                      mask_we_i,
   input  logic [N_IRQ-1:0]          mask_wdata_i,
   input  logic                      illop_i,
   input  logic                      ex_valid_i,
   input  logic [PC_W-1:0]           ex_pc_i,
   input  logic                      eret_i,
   output logic                      take_o,
   output logic [PC_W-1:0]           take_vec_o,
   output logic [PC_W-1:0]           epc_o,
   output logic [cause_w(N_IRQ)-1:0] cause_o,
   output logic [N_IRQ-1:0]          irq_ack_o,
   output logic [N_IRQ-1:0]          pending_o,
   output logic                      in_handler_o
);
   localparam int CW = cause_w(N_IRQ);
   localparam int IW = id_w(N_IRQ);
   irq_state_e       state_q;
   logic [N_IRQ-1:0] mask_q, pending_q, irq_ack_q, irq_ack_d;
   logic [PC_W-1:0]  epc_q, epc_d;
   logic [CW-1:0]    cause_q, cause_d;
   logic             arb_valid, user_ex, take_irq;
   logic [IW-1:0]    arb_id;
`ifdef IRQ_CTRL_RR_EN
   logic [IW-1:0]    ptr_q;
`endif
   irq_arbiter #(.N_IRQ(N_IRQ)) u_arb (
`ifdef IRQ_CTRL_RR_EN
      .ptr_i   (ptr_q),
`endif
      .pend_i  (pending_q),
      .valid_o (arb_valid),
      .id_o    (arb_id)
   );
   assign user_ex    = ex_valid_i & ~ex_pc_i[PC_W-1];
   // Gating with rst_ni drops take the instant reset asserts, even with illop held high.
   assign take_o     = rst_ni & (state_q == ST_USER) & user_ex & (illop_i | arb_valid);
   assign take_irq   = take_o & ~illop_i;
   assign take_vec_o = illop_i ? VEC_EXC : VEC_IRQ;
   assign epc_d      = illop_i ? ex_pc_i + PC_W'(4) : ex_pc_i;
   assign cause_d    = illop_i ? CW'(CAUSE_ILLOP) << (CW - 1) : CW'(arb_id);
   assign irq_ack_d  = take_irq ? N_IRQ'(1) << arb_id : '0;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q   <= ST_USER;
         mask_q    <= MASK_RST;
         pending_q <= '0;
         epc_q     <= '0;
         cause_q   <= '0;
         irq_ack_q <= '0;
`ifdef IRQ_CTRL_RR_EN
         ptr_q     <= IW'(N_IRQ - 1);
`endif
      end else begin
         pending_q <= irq_i & mask_q;
         irq_ack_q <= irq_ack_d;
         if (mask_we_i) mask_q <= mask_wdata_i;
         if (take_o) begin
            epc_q   <= epc_d;
            cause_q <= cause_d;
         end
`ifdef IRQ_CTRL_RR_EN
         if (take_irq) ptr_q <= arb_id;
`endif
         case (state_q)
            ST_USER:    if (take_o) state_q <= ST_HANDLER;
            ST_HANDLER: if (ex_valid_i & eret_i) state_q <= ST_RESUME;
            ST_RESUME:  if (user_ex) state_q <= ST_USER;
            default:    state_q <= ST_USER;
         endcase
      end
   assign epc_o        = epc_q;
   assign cause_o      = cause_q;
   assign irq_ack_o    = irq_ack_q;
   assign pending_o    = pending_q;
   assign in_handler_o = (state_q == ST_HANDLER);
endmodule

// File: tb/tb_irq_exc_ctrl.sv
// tb_irq_exc_ctrl: directed scenarios plus randomized traffic checked against a behavioural model.
// Honours IRQ_CTRL_RR_EN for the expected arbitration order.
module tb_irq_exc_ctrl;
   import irq_exc_pkg::*;
   localparam int N = 4;
   localparam int PW = 32;
   localparam int CW = cause_w(N);
   logic          clk = 1'b0, rst_n = 1'b0;
   logic [N-1:0]  irq = '0, mask_wdata = '0;
   logic          mask_we = 1'b0, illop = 1'b0, ex_valid = 1'b0, eret = 1'b0;
   logic [PW-1:0] ex_pc = '0;
   logic          take, in_handler;
   logic [PW-1:0] take_vec, epc;
   logic [CW-1:0] cause;
   logic [N-1:0]  irq_ack, pending;
   int errs = 0, checks = 0;
   int            md, m_last;
   logic [N-1:0]  m_mask, m_pend, m_ack;
   logic [PW-1:0] m_epc;
   logic [CW-1:0] m_cause;
   always #5 clk = ~clk;
   irq_exc_ctrl #(.N_IRQ(N), .PC_W(PW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .irq_i(irq), .mask_we_i(mask_we), .mask_wdata_i(mask_wdata),
      .illop_i(illop), .ex_valid_i(ex_valid), .ex_pc_i(ex_pc), .eret_i(eret),
      .take_o(take), .take_vec_o(take_vec), .epc_o(epc), .cause_o(cause),
      .irq_ack_o(irq_ack), .pending_o(pending), .in_handler_o(in_handler)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic m_reset();
      md = 0; m_last = N - 1; m_mask = '1; m_pend = '0; m_ack = '0; m_epc = '0; m_cause = '0;
   endtask
   function automatic int pick();
`ifdef IRQ_CTRL_RR_EN
      for (int k = 1; k <= N; k++) if (m_pend[(m_last + k) % N]) return (m_last + k) % N;
`else
      for (int k = 0; k < N; k++) if (m_pend[k]) return k;
`endif
      return 0;
   endfunction
   task automatic step();
      bit t;
      int id;
      @(negedge clk);
      t = (md == 0) && ex_valid && !ex_pc[PW-1] && (illop || m_pend != 0);
      chk("take", take, t);
      if (t) chk("take_vec", take_vec, illop ? 32'h8000_0008 : 32'h8000_0004);
      chk("pending", pending, m_pend);
      chk("epc", epc, m_epc);
      chk("cause", cause, m_cause);
      chk("irq_ack", irq_ack, m_ack);
      chk("in_handler", in_handler, md == 1);
      m_ack = '0;
      if (t) begin
         if (illop) begin
            m_epc = ex_pc + 4; m_cause = CW'(1) << (CW - 1);
         end else begin
            id = pick(); m_epc = ex_pc; m_cause = CW'(id); m_ack = N'(1) << id; m_last = id;
         end
         md = 1;
      end else if (md == 1 && ex_valid && eret) md = 2;
      else if (md == 2 && ex_valid && !ex_pc[PW-1]) md = 0;
      m_pend = irq & m_mask;
      if (mask_we) m_mask = mask_wdata;
      @(posedge clk); #1;
   endtask
   task automatic drive(input bit v, input logic [PW-1:0] pc, input bit il, input bit er);
      ex_valid = v; ex_pc = pc; illop = il; eret = er;
   endtask
   task automatic leave();
      drive(0, 0, 0, 0); step();
      drive(1, 32'h8000_0020, 0, 1); step();
      drive(1, 32'h0000_0600, 0, 0); step();
      drive(0, 0, 0, 0);
   endtask
   task automatic do_reset();
      #2 rst_n = 1'b0; mask_we = 1'b0;
      #1;
      chk("rst_in_handler", in_handler, 0);
      chk("rst_epc", epc, 0);
      chk("rst_take", take, 0);
      m_reset();
      @(posedge clk); #1 rst_n = 1'b1;
   endtask
   initial begin
      logic [CW-1:0] rr_exp [3];
      m_reset();
      irq = 4'b0100;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      chk("t1_pending", pending, 4'b0100);
      drive(1, 32'h40, 0, 0); step();
      chk("t1_epc", epc, 32'h40);
      chk("t1_cause", cause, 2);
      chk("t1_ack", irq_ack, 4'b0100);
      leave();
      irq = 4'b0001; step();
      drive(1, 32'h100, 1, 0); step();
      chk("t2_cause", cause, 3'b100);
      chk("t2_epc", epc, 32'h104);
      leave();
      drive(1, 32'h108, 0, 0); step();
      chk("t2_irq_cause", cause, 0);
      chk("t2_irq_ack", irq_ack, 4'b0001);
      irq = 4'b1111;
      drive(1, 32'h200, 1, 0); step(); step();
      chk("t3_in_handler", in_handler, 1);
      drive(1, 32'h8000_0020, 0, 1); step();
      drive(0, 0, 0, 0); step(); step();
      drive(1, 32'h204, 0, 0); step(); step();
`ifdef IRQ_CTRL_RR_EN
      chk("t3_cause", cause, 1);
`else
      chk("t3_cause", cause, 0);
`endif
      leave();
      mask_we = 1'b1; mask_wdata = 4'b0000; step();
      mask_we = 1'b0; step();
      chk("t4_pending_masked", pending, 0);
      drive(1, 32'h300, 0, 0); step(); step();
      chk("t4_no_take", in_handler, 0);
      drive(0, 0, 0, 0); mask_we = 1'b1; mask_wdata = 4'b1000; step();
      mask_we = 1'b0; step();
      drive(1, 32'h300, 0, 0); step();
      chk("t4_cause", cause, 3);
      chk("t4_ack", irq_ack, 4'b1000);
      leave();
      irq = 4'b0011; mask_we = 1'b1; mask_wdata = 4'b1111; step();
      mask_we = 1'b0; step();
`ifdef IRQ_CTRL_RR_EN
      rr_exp = '{CW'(0), CW'(1), CW'(0)};
`else
      rr_exp = '{CW'(0), CW'(0), CW'(0)};
`endif
      for (int s = 0; s < 3; s++) begin
         drive(1, 32'h400, 0, 0); step();
         chk("t5_served", cause, rr_exp[s]);
         leave();
      end
      drive(1, 32'h500, 0, 0); step();
      chk("t6_in_handler", in_handler, 1);
      drive(1, 32'h500, 1, 0);
      do_reset();
      drive(1, 32'h500, 0, 0); step(); step();
      chk("t6_retake", in_handler, 1);
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         if ($urandom_range(0, 7) == 0) irq = N'($urandom);
         mask_we = ($urandom_range(0, 15) == 0);
         mask_wdata = N'($urandom);
         illop = ($urandom_range(0, 7) == 0);
         ex_valid = ($urandom_range(0, 3) != 0);
         eret = ($urandom_range(0, 3) == 0);
         ex_pc = {($urandom_range(0, 3) == 0), 29'($urandom), 2'b00};
         step();
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
